uart_byte_rx: RTL and testbench

// - Serial-to-byte UART receiver; link-side counterpart of the byte transmitter.
// - 8N1 frames on rs232_rx: start=0, 8 data bits LSB first, stop=1.
// - Oversamples each bit 16x with a 3-sample majority vote and returns one byte per frame.
// - Reports a framing error on a bad stop bit.
// - Sits between the board RX pin and the command/loopback logic.

---
 rtl/uart_byte_rx_pkg.sv | 42 ++++
 rtl/uart_byte_rx_if.sv | 10 +
 rtl/uart_byte_rx_bps_gen.sv | 54 +++++
 rtl/uart_byte_rx.sv | 177 +++++++++++++++++
 tb/tb_uart_byte_rx.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the UART byte receiver: rate codes, oversample divisor
// helper, majority vote helper and receiver FSM state encodings.
package uart_byte_rx_pkg;

    localparam logic [3:0] BAUD_9600   = 4'd0;
    localparam logic [3:0] BAUD_19200  = 4'd1;
    localparam logic [3:0] BAUD_38400  = 4'd2;
    localparam logic [3:0] BAUD_57600  = 4'd3;
    localparam logic [3:0] BAUD_115200 = 4'd4;

    localparam logic [3:0] SUB_SAMPLE_A = 4'd6;
    localparam logic [3:0] SUB_SAMPLE_B = 4'd7;
    localparam logic [3:0] SUB_VOTE     = 4'd8;
    localparam logic [3:0] SUB_LAST     = 4'd15;
    localparam logic [2:0] BIT_LAST     = 3'd7;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    // Oversample divisor: one tick every DIV+1 clocks at 16x the baud rate.
    function automatic logic [15:0] baud_div(input logic [3:0] code, input int unsigned clk_freq);
        int unsigned baud;
        case (code)
            BAUD_19200:  baud = 32'd19200;
            BAUD_38400:  baud = 32'd38400;
            BAUD_57600:  baud = 32'd57600;
            BAUD_115200: baud = 32'd115200;
            default:     baud = 32'd9600;
        endcase
        baud_div = 16'(clk_freq / (baud * 32'd16) - 32'd1);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Received-byte interface: the receiver drives it, the command/loopback logic consumes it.
interface uart_byte_rx_if;
    logic [7:0] data_rx;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    modport master (output data_rx, output rx_done, output frame_err, output rx_busy);
    modport slave  (input data_rx, input rx_done, input frame_err, input rx_busy);
endinterface

// File: rtl/uart_byte_rx_bps_gen.sv
// 16x oversample tick generator for the receiver; restarted on start detect so the
// tick phase follows the falling edge of the start bit.
module uart_byte_rx_bps_gen #(
    parameter int unsigned CLK_FREQ = 32'd50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_baud,
    input  logic       i_clear,
    output logic       o_bps_tick
);
    import uart_byte_rx_pkg::*;

    localparam logic [15:0] DIV_9600   = baud_div(BAUD_9600,   CLK_FREQ);
    localparam logic [15:0] DIV_19200  = baud_div(BAUD_19200,  CLK_FREQ);
    localparam logic [15:0] DIV_38400  = baud_div(BAUD_38400,  CLK_FREQ);
    localparam logic [15:0] DIV_57600  = baud_div(BAUD_57600,  CLK_FREQ);
    localparam logic [15:0] DIV_115200 = baud_div(BAUD_115200, CLK_FREQ);

    logic [15:0] w_div;
    logic [15:0] r_cnt;
    logic        r_tick;

    // Divisor selected by the latched rate code
    always_comb begin
        case (i_baud)
            BAUD_19200:  w_div = DIV_19200;
            BAUD_38400:  w_div = DIV_38400;
            BAUD_57600:  w_div = DIV_57600;
            BAUD_115200: w_div = DIV_115200;
            default:     w_div = DIV_9600;
        endcase
    end

    // Divider counter with registered tick, realigned by clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= 16'd0;
            r_tick <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= 16'd0;
            r_tick <= 1'b0;
        end else if (r_cnt >= w_div) begin
            r_cnt  <= 16'd0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 16'd1;
            r_tick <= 1'b0;
        end
    end

    assign o_bps_tick = r_tick;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-flop line synchroniser, 16x oversampling with a 3-sample
// majority vote, one byte and a framing-error flag per frame.
module uart_byte_rx #(
    parameter int unsigned CLK_FREQ = 32'd50_000_000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     baud_set,
    input  logic           rs232_rx,
    uart_byte_rx_if.master rx_if
);
    import uart_byte_rx_pkg::*;

    rx_state_e  r_state;
    rx_state_e  w_next;
    logic       r_rx_s1;
    logic       r_rx_s2;
    logic       r_rx_s3;
    logic [3:0] r_baud;
    logic [3:0] r_sub;
    logic [2:0] r_bit;
    logic       r_s6;
    logic       r_s7;
    logic [7:0] r_shift;
    logic [7:0] r_data_rx;
    logic       r_rx_done;
    logic       r_frame_err;
    logic       r_rx_busy;

    logic       w_tick;
    logic       w_fall;
    logic       w_vote;
    logic       w_mid;
    logic       w_end;
    logic       w_start;
    logic       w_abort;
    logic       w_shift;
    logic       w_finish;

    uart_byte_rx_bps_gen #(.CLK_FREQ(CLK_FREQ)) u_bps_gen (
        .clk        (clk),
        .rst        (rst),
        .i_baud     (r_baud),
        .i_clear    (w_start),
        .o_bps_tick (w_tick)
    );

    assign w_fall = r_rx_s3 & ~r_rx_s2;
    assign w_vote = maj3(r_s6, r_s7, r_rx_s2);
    assign w_mid  = w_tick & (r_sub == SUB_VOTE);
    assign w_end  = w_tick & (r_sub == SUB_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_abort  = 1'b0;
        w_shift  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_next  = RX_START;
                    w_start = 1'b1;
                end else begin
                    w_next = RX_IDLE;
                end
            end
            RX_START: begin
                if (w_mid && w_vote) begin
                    w_next  = RX_IDLE;
                    w_abort = 1'b1;
                end else if (w_end) begin
                    w_next = RX_DATA;
                end else begin
                    w_next = RX_START;
                end
            end
            RX_DATA: begin
                w_shift = w_mid;
                if (w_end && (r_bit == BIT_LAST)) begin
                    w_next = RX_STOP;
                end else begin
                    w_next = RX_DATA;
                end
            end
            RX_STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is never missed
                if (w_mid) begin
                    w_finish = 1'b1;
                    w_next   = w_vote ? RX_IDLE : RX_BREAK;
                end else begin
                    w_next = RX_STOP;
                end
            end
            RX_BREAK: begin
                if (r_rx_s2) begin
                    w_next = RX_IDLE;
                end else begin
                    w_next = RX_BREAK;
                end
            end
            default: begin
                w_next = RX_IDLE;
            end
        endcase
    end

    // Synchroniser, counters, sampling, shift register and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_s3     <= 1'b1;
            r_baud      <= 4'd0;
            r_sub       <= 4'd0;
            r_bit       <= 3'd0;
            r_s6        <= 1'b0;
            r_s7        <= 1'b0;
            r_shift     <= 8'd0;
            r_data_rx   <= 8'd0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_busy   <= 1'b0;
        end else begin
            r_rx_s1     <= rs232_rx;
            r_rx_s2     <= r_rx_s1;
            r_rx_s3     <= r_rx_s2;
            r_rx_done   <= w_finish;
            r_frame_err <= w_finish & ~w_vote;
            if (w_start) begin
                r_baud <= baud_set;
                r_sub  <= 4'd0;
                r_bit  <= 3'd0;
            end else begin
                if (w_tick && (r_state != RX_IDLE) && (r_state != RX_BREAK)) begin
                    r_sub <= r_sub + 4'd1;
                end
                if ((r_state == RX_DATA) && w_end) begin
                    r_bit <= r_bit + 3'd1;
                end
            end
            if (w_tick && (r_sub == SUB_SAMPLE_A)) begin
                r_s6 <= r_rx_s2;
            end
            if (w_tick && (r_sub == SUB_SAMPLE_B)) begin
                r_s7 <= r_rx_s2;
            end
            if (w_shift) begin
                r_shift <= {w_vote, r_shift[7:1]};
            end
            if (w_finish) begin
                r_data_rx <= r_shift;
            end
            if (w_start) begin
                r_rx_busy <= 1'b1;
            end else if (w_abort || w_finish) begin
                r_rx_busy <= 1'b0;
            end
        end
    end

    assign rx_if.data_rx   = r_data_rx;
    assign rx_if.rx_done   = r_rx_done;
    assign rx_if.frame_err = r_frame_err;
    assign rx_if.rx_busy   = r_rx_busy;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: table of single frames plus directed
// sequences for glitch, break, back-to-back, baud change and mid-frame reset.
module tb_uart_byte_rx;

    // 25 MHz: 115200 -> DIV=12, 208 clk/bit; 9600 -> DIV=161, 2592 clk/bit
    localparam int unsigned CLK_FREQ = 25_000_000;
    localparam int BIT4 = 208;
    localparam int BIT0 = 2592;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bitlen;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] baud_set;
    logic       rs232_rx;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         err_vio = 0;
    logic [7:0] last_data = 8'd0;
    logic       last_err = 1'b0;
    logic [8:0] rx_q[$];

    uart_byte_rx_if rx_if ();

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_set (baud_set),
        .rs232_rx (rs232_rx),
        .rx_if    (rx_if)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rst && rx_if.rx_done) begin
            done_cnt  <= done_cnt + 1;
            last_data <= rx_if.data_rx;
            last_err  <= rx_if.frame_err;
            rx_q.push_back({rx_if.frame_err, rx_if.data_rx});
        end
        if (rst && rx_if.frame_err && !rx_if.rx_done) begin
            err_vio <= err_vio + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int n);
        rs232_rx = b;
        wait_clks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int n);
        send_bit(1'b0, n);
        for (int k = 0; k < 8; k++) send_bit(d[k], n);
        send_bit(stop, n);
    endtask

    vec_t vecs[4];
    int   d0;

    initial begin
        vecs[0] = '{8'h55, 1'b1, BIT4,     8'h55, 1'b0};
        vecs[1] = '{8'hC9, 1'b1, BIT4 - 4, 8'hC9, 1'b0};
        vecs[2] = '{8'hC9, 1'b1, BIT4 + 4, 8'hC9, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, BIT4,     8'hA5, 1'b0};

        rst = 1'b0;
        baud_set = 4'd4;
        rs232_rx = 1'b1;
        wait_clks(5);
        check("rst_data", {24'd0, rx_if.data_rx}, 32'h00);
        check("rst_done", {31'd0, rx_if.rx_done}, 32'd0);
        check("rst_err", {31'd0, rx_if.frame_err}, 32'd0);
        check("rst_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        rst = 1'b1;
        wait_clks(20);

        for (int i = 0; i < 4; i++) begin
            d0 = done_cnt;
            fork
                send_frame(vecs[i].data, vecs[i].stop, vecs[i].bitlen);
                begin
                    wait_clks(5 * vecs[i].bitlen);
                    check("busy_mid", {31'd0, rx_if.rx_busy}, 32'd1);
                end
            join
            wait_clks(4);
            check("vec_done", done_cnt - d0, 32'd1);
            check("vec_data", {24'd0, last_data}, {24'd0, vecs[i].exp_data});
            check("vec_err", {31'd0, last_err}, {31'd0, vecs[i].exp_err});
            check("vec_busy_end", {31'd0, rx_if.rx_busy}, 32'd0);
        end

        // short low pulse: start vote fails, frame discarded
        d0 = done_cnt;
        send_bit(1'b0, 10);
        check("glitch_busy", {31'd0, rx_if.rx_busy}, 32'd1);
        send_bit(1'b0, 38);
        send_bit(1'b1, 3 * BIT4);
        check("glitch_nodone", done_cnt - d0, 32'd0);
        check("glitch_busy_end", {31'd0, rx_if.rx_busy}, 32'd0);

        // bad stop bit followed by a 20-bit break
        d0 = done_cnt;
        send_frame(8'hA3, 1'b0, BIT4);
        send_bit(1'b0, 20 * BIT4);
        check("brk_done", done_cnt - d0, 32'd1);
        check("brk_data", {24'd0, last_data}, 32'hA3);
        check("brk_err", {31'd0, last_err}, 32'd1);
        send_bit(1'b1, 2 * BIT4);
        check("brk_single", done_cnt - d0, 32'd1);
        check("brk_busy", {31'd0, rx_if.rx_busy}, 32'd0);

        // back-to-back frames, no idle gap
        rx_q.delete();
        send_frame(8'h00, 1'b1, BIT4);
        send_frame(8'hFF, 1'b1, BIT4);
        send_frame(8'h3C, 1'b1, BIT4);
        wait_clks(2 * BIT4);
        check("b2b_count", rx_q.size(), 32'd3);
        if (rx_q.size() == 3) begin
            check("b2b_0", {23'd0, rx_q[0]}, 32'h000);
            check("b2b_1", {23'd0, rx_q[1]}, 32'h0FF);
            check("b2b_2", {23'd0, rx_q[2]}, 32'h03C);
        end

        // 9600 frame with baud_set changed to 115200 during bit 3
        baud_set = 4'd0;
        wait_clks(10);
        d0 = done_cnt;
        fork
            send_frame(8'h81, 1'b1, BIT0);
            begin
                wait_clks(4 * BIT0 + BIT0 / 2);
                baud_set = 4'd4;
            end
        join
        wait_clks(4);
        check("b0_done", done_cnt - d0, 32'd1);
        check("b0_data", {24'd0, last_data}, 32'h81);
        check("b0_err", {31'd0, last_err}, 32'd0);

        // reset during bit 4 of frame 0x5A
        d0 = done_cnt;
        send_bit(1'b0, BIT4);
        send_bit(1'b0, BIT4);
        send_bit(1'b1, BIT4);
        send_bit(1'b0, BIT4);
        send_bit(1'b1, BIT4);
        send_bit(1'b1, BIT4 / 2);
        rst = 1'b0;
        rs232_rx = 1'b1;
        wait_clks(3);
        check("mrst_data", {24'd0, rx_if.data_rx}, 32'h00);
        check("mrst_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        rst = 1'b1;
        wait_clks(3 * BIT4);
        check("mrst_nodone", done_cnt - d0, 32'd0);
        check("mrst_data_after", {24'd0, rx_if.data_rx}, 32'h00);
        check("mrst_busy_after", {31'd0, rx_if.rx_busy}, 32'd0);

        d0 = done_cnt;
        send_frame(8'h3C, 1'b1, BIT4);
        wait_clks(4);
        check("post_done", done_cnt - d0, 32'd1);
        check("post_data", {24'd0, last_data}, 32'h3C);
        check("post_err", {31'd0, last_err}, 32'd0);

        check("err_without_done", err_vio, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
